// File: rtl/mv_pkg.sv
// Shared definitions for the matrix-vector operand path: element width,
// matrix dimension, frame length and the loader state encoding.
package mv_pkg;
  localparam int DW    = 7;
  localparam int N     = 4;
  localparam int NELEM = N * N + N;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    PRESENT = 2'd1,
    HOLD    = 2'd2
  } state_t;
endpackage

// File: rtl/mat_vec_loader.sv
// Collects a streamed N x N matrix plus N-vector, presents it to the multiplier
// and holds it steady until the multiplier reports completion.
module mat_vec_loader
  import mv_pkg::*;
#(
  parameter int DW = mv_pkg::DW,
  parameter int N  = mv_pkg::N
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [N*N*DW-1:0] a_flat,
  output logic [N*DW-1:0]   b_flat,
  output logic              out_valid,
  input  logic              out_ready,
  input  logic              mul_done,
  output logic              frame_err,
  output logic              busy
);
  localparam int NE = N * N + N;
  localparam int IW = $clog2(NE);
  localparam logic [IW-1:0] LAST_IDX = IW'(NE - 1);

  state_t           state;
  logic [IW-1:0]    idx;
  logic [NE*DW-1:0] data_q;
  logic             accept;
  logic             idx_last;

  assign in_ready = (state == LOAD) && !rst;
  assign accept   = in_valid && in_ready;
  assign idx_last = (idx == LAST_IDX);

  // Matrix occupies the low N*N slots in row-major order, vector the top N.
  assign a_flat = data_q[N*N*DW-1:0];
  assign b_flat = data_q[NE*DW-1:N*N*DW];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      idx       <= '0;
      data_q    <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        LOAD: begin
          if (accept) begin
            data_q[int'(idx)*DW +: DW] <= in_data;
            if (idx_last && in_last) begin
              idx       <= '0;
              state     <= PRESENT;
              out_valid <= 1'b1;
              busy      <= 1'b1;
            end else if (idx_last || in_last) begin
              // Length mismatch: drop the frame; storage keeps whatever was written.
              idx       <= '0;
              frame_err <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        PRESENT: begin
          if (out_ready) begin
            state     <= HOLD;
            out_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (mul_done) begin
            state <= LOAD;
            busy  <= 1'b0;
          end
        end
        default: begin
          state     <= LOAD;
          idx       <= '0;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mat_vec_loader.sv
// Scoreboard bench for mat_vec_loader: directed frames push expected operand
// sets; a monitor compares them whenever out_valid rises.
module tb_mat_vec_loader;
  import mv_pkg::*;

  typedef struct {
    logic [N*N*DW-1:0] a;
    logic [N*DW-1:0]   b;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic [DW-1:0]     in_data = '0;
  logic              in_last = 1'b0;
  logic              in_ready;
  logic [N*N*DW-1:0] a_flat;
  logic [N*DW-1:0]   b_flat;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic              mul_done = 1'b0;
  logic              frame_err;
  logic              busy;

  int   tests = 0;
  int   fails = 0;
  int   err_pend = 0;
  int   acc = 0;
  exp_t sb[$];
  exp_t last_e;
  logic [DW-1:0] vals [NELEM];

  mat_vec_loader #(.DW(DW), .N(N)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_last(in_last), .in_ready(in_ready), .a_flat(a_flat), .b_flat(b_flat),
    .out_valid(out_valid), .out_ready(out_ready), .mul_done(mul_done),
    .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp();
    exp_t e;
    e.a = '0;
    e.b = '0;
    for (int k = 0; k < N * N; k++) e.a[k*DW +: DW] = vals[k];
    for (int k = 0; k < N; k++) e.b[k*DW +: DW] = vals[N*N+k];
    sb.push_back(e);
  endtask

  // Streams cnt elements from vals; in_last on 1-based position last_pos.
  task automatic send(input int cnt, input int last_pos, input bit gap);
    for (int i = 0; i < cnt; i++) begin
      if (gap && i > 0) begin
        in_valid = 1'b0;
        step();
      end
      in_valid = 1'b1;
      in_data  = vals[i];
      in_last  = (i + 1 == last_pos);
      begin
        int t;
        t = 0;
        while (!in_ready && t < 50) begin
          step();
          t++;
        end
        if (t == 50) chk("accept_timeout", 1, 0);
        else step();
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // PRESENT -> HOLD -> LOAD with new data offered throughout HOLD.
  task automatic finish_frame();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("hold_out_valid", out_valid, 0);
    chk("hold_busy", busy, 1);
    in_valid = 1'b1;
    in_data  = 7'h55;
    in_last  = 1'b1;
    repeat (7) begin
      chk("hold_in_ready", in_ready, 0);
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    mul_done = 1'b1;
    step();
    mul_done = 1'b0;
    chk("post_done_in_ready", in_ready, 1);
    chk("post_done_busy", busy, 0);
    chk("post_done_a_kept", a_flat, last_e.a);
    chk("post_done_b_kept", b_flat, last_e.b);
  endtask

  initial begin : monitor
    logic ov_prev, fe_prev;
    exp_t e;
    ov_prev = 1'b0;
    fe_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ov_prev = 1'b0;
        fe_prev = 1'b0;
      end else begin
        if (out_valid && !ov_prev) begin
          if (sb.size() == 0) begin
            chk("unexpected_out_valid", 1, 0);
          end else begin
            e = sb.pop_front();
            last_e = e;
            chk("a_flat", a_flat, e.a);
            chk("b_flat", b_flat, e.b);
          end
        end
        if (busy && !out_valid) begin
          chk("hold_stable_a", a_flat, last_e.a);
          chk("hold_stable_b", b_flat, last_e.b);
        end
        if (frame_err) begin
          if (fe_prev) chk("frame_err_width", 2, 1);
          else if (err_pend == 0) chk("unexpected_frame_err", 1, 0);
          else begin
            err_pend--;
            tests++;
          end
        end
        ov_prev = out_valid;
        fe_prev = frame_err;
      end
    end
  end

  initial begin : acc_counter
    forever begin
      @(posedge clk);
      if (in_valid && in_ready && !rst) acc++;
    end
  end

  initial begin : stim
    int acc0;
    last_e.a = '0;
    last_e.b = '0;
    step();
    step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_a_flat", a_flat, 0);
    chk("rst_b_flat", b_flat, 0);
    rst = 1'b0;
    #1;
    chk("in_ready_after_rst", in_ready, 1);
    step();

    // Frame A: matrix 1..16, vector 1..4; stray mul_done in LOAD is ignored.
    for (int k = 0; k < N * N; k++) vals[k] = DW'(k + 1);
    for (int k = 0; k < N; k++) vals[N*N+k] = DW'(k + 1);
    mul_done = 1'b1;
    step();
    mul_done = 1'b0;
    push_exp();
    send(NELEM, NELEM, 1'b0);
    chk("A_out_valid", out_valid, 1);
    chk("A_a33", a_flat[15*DW +: DW], 16);
    chk("A_b3", b_flat[3*DW +: DW], 4);
    chk("A_busy", busy, 1);
    in_valid = 1'b1;
    in_data  = 7'h7f;
    for (int c = 0; c < 5; c++) begin
      mul_done = (c == 2);
      step();
      chk("present_out_valid", out_valid, 1);
      chk("present_in_ready", in_ready, 0);
    end
    mul_done = 1'b0;
    in_valid = 1'b0;
    finish_frame();

    // Same frame with in_valid toggling every other cycle.
    push_exp();
    acc0 = acc;
    send(NELEM, NELEM, 1'b1);
    chk("gap_accepts", acc - acc0, 20);
    chk("gap_out_valid", out_valid, 1);
    chk("gap_a33", a_flat[15*DW +: DW], 16);
    finish_frame();

    // in_last on element 10: frame dropped.
    err_pend++;
    send(10, 10, 1'b0);
    chk("short_out_valid", out_valid, 0);
    chk("short_in_ready", in_ready, 1);
    step();
    chk("short_err_cleared", frame_err, 0);

    // Frame C: 127 down to 108, well formed.
    for (int k = 0; k < NELEM; k++) vals[k] = DW'(127 - k);
    push_exp();
    send(NELEM, NELEM, 1'b0);
    chk("C_a00", a_flat[0 +: DW], 127);
    chk("C_b3", b_flat[3*DW +: DW], 108);
    finish_frame();

    // 20 elements without in_last: dropped.
    err_pend++;
    send(NELEM, 0, 1'b0);
    chk("long_out_valid", out_valid, 0);
    step();
    chk("long_busy", busy, 0);

    // Reset after 12 accepts, then a fresh frame.
    for (int k = 0; k < NELEM; k++) vals[k] = DW'(3 * k + 5);
    send(12, 0, 1'b0);
    rst = 1'b1;
    step();
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_a_flat", a_flat, 0);
    chk("midrst_b_flat", b_flat, 0);
    rst = 1'b0;
    #1;
    chk("midrst_in_ready_rel", in_ready, 1);
    push_exp();
    send(NELEM, NELEM, 1'b0);
    chk("D_out_valid", out_valid, 1);
    chk("D_b0", b_flat[0 +: DW], 53);
    finish_frame();

    repeat (5) step();
    chk("sb_drained", sb.size(), 0);
    chk("frame_err_seen", err_pend, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mat_vec_loader.md
MAT_VEC_LOADER -- requirements
Module: mat_vec_loader

Interface
REQ-001 The block SHALL have a synchronous, active-high reset rst and a clock clk.
REQ-002 Parameter DW, default 7: element width in bits.
REQ-003 Parameter N, default 4: matrix dimension; frame length NELEM = N*N+N = 20.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 in_valid  in  1  upstream element valid.
REQ-007 in_data  in  DW  element value, unsigned.
REQ-008 in_last  in  1  marks final element of frame.
REQ-009 in_ready  out  1  loader accepts element this cycle.
REQ-010 a_flat  out  N*N*DW  matrix; element a[i][j] at bits [(i*N+j)*DW +: DW].
REQ-011 b_flat  out  N*DW  vector; b[k] at bits [k*DW +: DW].
REQ-012 out_valid  out  1  complete operand set presented.
REQ-013 out_ready  in  1  multiplier accepts operand set.
REQ-014 mul_done  in  1  one-cycle pulse from multiplier when c3 is written.
REQ-015 frame_err  out  1  one-cycle pulse on malformed frame.
REQ-016 busy  out  1  high in PRESENT or HOLD.

Function
REQ-017 States SHALL be LOAD, PRESENT, HOLD; encoding per shared package.
REQ-018 in_ready SHALL be 1 exactly when state is LOAD and rst is 0.
REQ-019 An element is accepted on a clk edge where in_valid and in_ready are both 1; nothing else advances the element counter.
REQ-020 Accepted elements SHALL be stored in order a00,a01,...,a33,b0,...,b3 (row-major, then vector) using a 5-bit counter idx 0..19.
REQ-021 Acceptance with idx=19 and in_last=1: counter to 0, state to PRESENT, out_valid=1 from the next cycle.
REQ-022 Acceptance with in_last=1 and idx<19: frame discarded, idx to 0, frame_err pulsed next cycle, state stays LOAD.
REQ-023 Acceptance with idx=19 and in_last=0: frame discarded, idx to 0, frame_err pulsed next cycle, state stays LOAD.
REQ-024 In PRESENT, out_valid and out_ready both 1 at a clk edge: state to HOLD, out_valid=0 from the next cycle.
REQ-025 In HOLD, mul_done=1: state to LOAD, in_ready=1 from the next cycle.
REQ-026 mul_done SHALL be ignored in LOAD and PRESENT; out_ready SHALL be ignored outside PRESENT.
REQ-027 a_flat and b_flat SHALL be stable from out_valid rising until the cycle after mul_done; storage SHALL be written only in LOAD.
REQ-028 A discarded frame SHALL leave a_flat/b_flat holding partially overwritten data; out_valid SHALL not assert for it.
REQ-029 Minimum frame-to-frame throughput: 20 load + 1 present + HOLD duration (7 cycles for the downstream multiplier) cycles.
REQ-030 No arithmetic on elements; widths are pass-through, no truncation.

Reset
REQ-031 With rst=1 at a clk edge: state=LOAD, idx=0, a_flat=0, b_flat=0, out_valid=0, frame_err=0, busy=0.
REQ-032 rst SHALL take priority over all other inputs, including mid-frame and in HOLD; a partial frame is dropped.
REQ-033 in_ready SHALL be 0 while rst=1 and 1 in the first cycle after rst falls.

Structure
REQ-034 Shared package mv_pkg SHALL hold DW, N, NELEM and the state enum; the downstream multiplier imports the same package.
REQ-035 Single module; no sub-module. Counter, FSM and operand registers SHALL be in mat_vec_loader.

Verification
REQ-036 Stream values 1..16 as matrix and 1,2,3,4 as vector, in_last on element 20 -> out_valid after 20 accepts; a_flat element a[3][3]=16; b[3]=4.
REQ-037 in_valid toggled every other cycle over a 20-element frame -> exactly 20 accepts, same outputs as REQ-036 case, out_valid on the cycle after the 20th accept.
REQ-038 in_last on element 10 -> frame_err pulse one cycle, out_valid stays 0; next well-formed frame loads correctly.
REQ-039 out_ready held 0 for 5 cycles in PRESENT -> out_valid held, in_ready 0; then out_ready=1 -> HOLD; mul_done after 7 cycles -> in_ready=1 next cycle.
REQ-040 in_valid=1 during HOLD with new data -> no accept, a_flat/b_flat unchanged until after mul_done.
REQ-041 rst asserted after 12 accepts -> all outputs 0, state LOAD; a fresh 20-element frame completes normally.
